// File: rtl/prg_save.sv
// PRG upload engine: serves a 2-byte load-address header, then PET RAM bytes fetched over DMA.
// Optional PRG_SAVE_BOUNDS_EN: RAM addresses beyond 2^RAM_AW read as 0xFF instead of wrapping.
module prg_save #(
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       start_addr,
  input  logic [15:0]       end_addr,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [16:0]       upload_size,
  output logic [RAM_AW-1:0] dma_addr,
  output logic              dma_rd,
  input  logic              dma_ack,
  input  logic [7:0]        dma_dout
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FETCH, LATCH} state_t;

  state_t              state_q;
  logic [15:0]         start_q;
  logic [16:0]         size_q;
  logic [7:0]          din_q;
  logic                wait_q;
  logic                dma_rd_q;
  logic [RAM_AW-1:0]   dma_addr_q;

  logic [16:0]         size_d;
  logic [RAM_AW-1:0]   dma_addr_d;
  logic                hdr0_s;
  logic                hdr1_s;
  logic                in_range_s;
  logic                oob_s;
  logic                fetch_req_s;

`ifdef PRG_SAVE_BOUNDS_EN
  logic [15:0]         ram_addr_s;
  assign ram_addr_s = start_q + ioctl_addr[15:0] - 16'd2;
  assign oob_s      = (32'(ram_addr_s) >> RAM_AW) != 32'd0;
  assign dma_addr_d = RAM_AW'(ram_addr_s);
`else
  assign dma_addr_d = RAM_AW'(start_q + ioctl_addr[15:0] - 16'd2);
  assign oob_s      = 1'b0;
`endif

  // File length: header plus the [start, end) byte range, header only when empty.
  assign size_d = (end_addr > start_addr) ?
                  ({1'b0, end_addr} - {1'b0, start_addr} + 17'd2) : 17'd2;

  assign hdr0_s      = (ioctl_addr == 25'd0);
  assign hdr1_s      = (ioctl_addr == 25'd1);
  assign in_range_s  = (ioctl_addr < {8'd0, size_q});
  assign fetch_req_s = (state_q == ACTIVE) && ioctl_upload && ioctl_rd &&
                       !hdr0_s && !hdr1_s && in_range_s && !oob_s;

  // The HPS must see the stall in the same cycle as the strobe that needs DMA.
  assign ioctl_wait  = wait_q | fetch_req_s;
  assign ioctl_din   = din_q;
  assign upload_size = size_q;
  assign dma_addr    = dma_addr_q;
  assign dma_rd      = dma_rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 16'd0;
      size_q     <= 17'd0;
      din_q      <= 8'd0;
      wait_q     <= 1'b0;
      dma_rd_q   <= 1'b0;
      dma_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ioctl_upload) begin
            state_q <= ACTIVE;
            start_q <= start_addr;
            size_q  <= size_d;
          end
        end
        ACTIVE: begin
          if (!ioctl_upload) begin
            state_q <= IDLE;
          end else if (ioctl_rd) begin
            if (hdr0_s) begin
              din_q <= start_q[7:0];
            end else if (hdr1_s) begin
              din_q <= start_q[15:8];
            end else if (!in_range_s) begin
              din_q <= 8'h00;
            end else if (oob_s) begin
              din_q <= 8'hFF;
            end else begin
              state_q    <= FETCH;
              wait_q     <= 1'b1;
              dma_rd_q   <= 1'b1;
              dma_addr_q <= dma_addr_d;
            end
          end
        end
        FETCH: begin
          if (!ioctl_upload) begin
            state_q  <= IDLE;
            wait_q   <= 1'b0;
            dma_rd_q <= 1'b0;
          end else if (dma_ack) begin
            state_q  <= LATCH;
            dma_rd_q <= 1'b0;
          end
        end
        LATCH: begin
          // RAM data is valid on dma_dout the cycle after the grant.
          wait_q <= 1'b0;
          if (!ioctl_upload) begin
            state_q <= IDLE;
          end else begin
            state_q <= ACTIVE;
            din_q   <= dma_dout;
          end
        end
        default: begin
          state_q  <= IDLE;
          wait_q   <= 1'b0;
          dma_rd_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prg_save.sv
// Randomised bench for prg_save: RAM/DMA responder plus a file-level model of the uploaded PRG image.
module tb_prg_save;
  localparam int RAM_AW = 14;
  localparam int RAM_SZ = 1 << RAM_AW;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       start_addr, end_addr;
  logic              ioctl_upload, ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [16:0]       upload_size;
  logic [RAM_AW-1:0] dma_addr;
  logic              dma_rd, dma_ack;
  logic [7:0]        dma_dout;

  int checks = 0;
  int failures = 0;

  logic [7:0]        ram [0:RAM_SZ-1];
  int                ack_delay = 1;
  bit                ack_enable = 1'b1;
  bit                force_ack = 1'b0;
  logic [RAM_AW-1:0] ack_addr = '0;

  prg_save #(.RAM_AW(RAM_AW)) dut (
    .clk(clk), .reset(reset), .start_addr(start_addr), .end_addr(end_addr),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .upload_size(upload_size),
    .dma_addr(dma_addr), .dma_rd(dma_rd), .dma_ack(dma_ack), .dma_dout(dma_dout)
  );

  always #5 clk = ~clk;

  // RAM side: grant after ack_delay cycles of dma_rd, data valid the cycle after the grant.
  initial begin
    int cnt;
    cnt = 0;
    dma_ack = 1'b0;
    dma_dout = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (dma_ack) dma_dout = ram[ack_addr];
      else         dma_dout = 8'($urandom);
      dma_ack = 1'b0;
      if (force_ack) begin
        dma_ack = 1'b1;
      end else if (dma_rd && ack_enable) begin
        cnt++;
        if (cnt >= ack_delay) begin
          dma_ack = 1'b1;
          ack_addr = dma_addr;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model of the uploaded file ----------------
  function automatic int model_size(int s, int e);
    return (e > s) ? (e - s + 2) : 2;
  endfunction

  function automatic bit model_oob(int s, int off);
    int a;
    a = (s + off - 2) & 32'hFFFF;
`ifdef PRG_SAVE_BOUNDS_EN
    return a >= RAM_SZ;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_dma(int s, int size, int off);
    return (off >= 2) && (off < size) && !model_oob(s, off);
  endfunction

  function automatic int model_ram_addr(int s, int off);
    return ((s + off - 2) & 32'hFFFF) % RAM_SZ;
  endfunction

  function automatic logic [7:0] model_byte(int s, int size, int off);
    if (off == 0) return 8'(s % 256);
    if (off == 1) return 8'((s / 256) % 256);
    if (off >= size) return 8'h00;
    if (model_oob(s, off)) return 8'hFF;
    return ram[model_ram_addr(s, off)];
  endfunction

  // ---------------- stimulus helpers (entered at posedge+1) ----------------
  task automatic begin_upload(input int s, input int e);
    start_addr = 16'(s);
    end_addr = 16'(e);
    ioctl_upload = 1'b1;
    @(posedge clk); #1;
    start_addr = 16'($urandom);
    end_addr = 16'($urandom);
  endtask

  task automatic end_upload();
    ioctl_upload = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic read_byte(input int off, output logic [7:0] din, output int wcyc,
                           output bit saw_dma, output logic [RAM_AW-1:0] daddr);
    bit w0;
    ioctl_addr = 25'(off);
    ioctl_rd = 1'b1;
    #1;
    w0 = ioctl_wait;
    saw_dma = 1'b0;
    daddr = '0;
    wcyc = w0 ? 1 : 0;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    while (ioctl_wait && wcyc < 200) begin
      if (dma_rd && !saw_dma) begin
        saw_dma = 1'b1;
        daddr = dma_addr;
      end
      wcyc++;
      @(posedge clk); #1;
    end
    if (dma_rd) saw_dma = 1'b1;
    din = ioctl_din;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_rd = 1'b0;
    ioctl_addr = '0;
    start_addr = 16'h1234;
    end_addr = 16'h5678;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ioctl_din !== 8'h00) begin failures++; $display("FAIL reset_din: got %h want 00", ioctl_din); end
    checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
    checks++; if (dma_rd !== 1'b0) begin failures++; $display("FAIL reset_dma_rd: got %b want 0", dma_rd); end
    checks++; if (dma_addr !== '0) begin failures++; $display("FAIL reset_dma_addr: got %h want 0", dma_addr); end
    checks++; if (upload_size !== 17'd0) begin failures++; $display("FAIL reset_size: got %h want 0", upload_size); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_header();
    logic [7:0] d; int w; bit sd; logic [RAM_AW-1:0] da;
    begin_upload(16'h0401, 16'h0405);
    checks++; if (upload_size !== 17'd6) begin failures++; $display("FAIL hdr_size: got %0d want 6", upload_size); end
    read_byte(0, d, w, sd, da);
    checks++; if (d !== 8'h01 || w != 0 || sd) begin failures++; $display("FAIL hdr_off0: din %h wait %0d dma %b want 01 0 0", d, w, sd); end
    read_byte(1, d, w, sd, da);
    checks++; if (d !== 8'h04 || w != 0 || sd) begin failures++; $display("FAIL hdr_off1: din %h wait %0d dma %b want 04 0 0", d, w, sd); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ioctl_din !== 8'h04) begin failures++; $display("FAIL hold_din: got %h want 04", ioctl_din); end
  endtask

  task automatic test_fetch();
    logic [7:0] d; int w; bit sd; logic [RAM_AW-1:0] da;
    ram[16'h0401] = 8'hA5;
    ack_delay = 3;
    read_byte(2, d, w, sd, da);
    checks++; if (da !== RAM_AW'(16'h0401) || !sd) begin failures++; $display("FAIL fetch_addr: got %h dma %b want 0401 1", da, sd); end
    checks++; if (w != 5) begin failures++; $display("FAIL fetch_wait: got %0d want 5", w); end
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL fetch_din: got %h want a5", d); end
    read_byte(6, d, w, sd, da);
    checks++; if (d !== 8'h00 || w != 0 || sd) begin failures++; $display("FAIL past_end: din %h wait %0d dma %b want 00 0 0", d, w, sd); end
    end_upload();
  endtask

  task automatic test_empty();
    logic [7:0] d; int w; bit sd; logic [RAM_AW-1:0] da;
    begin_upload(16'h0401, 16'h0400);
    checks++; if (upload_size !== 17'd2) begin failures++; $display("FAIL empty_size: got %0d want 2", upload_size); end
    read_byte(2, d, w, sd, da);
    checks++; if (d !== 8'h00 || w != 0 || sd) begin failures++; $display("FAIL empty_off2: din %h wait %0d dma %b want 00 0 0", d, w, sd); end
    end_upload();
  endtask

  task automatic test_random();
    logic [7:0] d; int w; bit sd; logic [RAM_AW-1:0] da;
    int s, e, size, off;
    for (int u = 0; u < 8; u++) begin
      s = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) e = (s - int'($urandom_range(0, 5))) & 32'hFFFF;
      else e = (s + int'($urandom_range(1, 12))) & 32'hFFFF;
      size = model_size(s, e);
      begin_upload(s, e);
      checks++; if (upload_size !== 17'(size)) begin failures++; $display("FAIL rnd_size: got %0d want %0d", upload_size, size); end
      for (int r = 0; r < 6; r++) begin
        off = int'($urandom_range(0, size + 2));
        ack_delay = int'($urandom_range(1, 6));
        read_byte(off, d, w, sd, da);
        checks++;
        if (d !== model_byte(s, size, off) || sd != model_dma(s, size, off) ||
            w != (model_dma(s, size, off) ? ack_delay + 2 : 0) ||
            (sd && da !== RAM_AW'(model_ram_addr(s, off)))) begin
          failures++;
          $display("FAIL rnd_read: s=%h off=%0d din %h wait %0d dma %b addr %h want %h %0d %b %h",
                   s, off, d, w, sd, da, model_byte(s, size, off),
                   model_dma(s, size, off) ? ack_delay + 2 : 0, model_dma(s, size, off),
                   RAM_AW'(model_ram_addr(s, off)));
        end
      end
      end_upload();
    end
  endtask

  task automatic test_ignore_during_wait();
    int n;
    begin_upload(16'h0200, 16'h0210);
    ack_delay = 4;
    ioctl_addr = 25'd5;
    ioctl_rd = 1'b1;
    @(posedge clk); #1;
    ioctl_addr = 25'd0;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 100) begin n++; @(posedge clk); #1; end
    checks++; if (n >= 100) begin failures++; $display("FAIL ignore_timeout: wait stuck high"); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ioctl_din !== ram[16'h0203] || dma_rd !== 1'b0) begin
      failures++; $display("FAIL ignore_rd: din %h dma_rd %b want %h 0", ioctl_din, dma_rd, ram[16'h0203]);
    end
    end_upload();
  endtask

  task automatic test_abort();
    logic [7:0] d0, d; int w; bit sd; logic [RAM_AW-1:0] da;
    begin_upload(16'h0100, 16'h0140);
    d0 = ioctl_din;
    ack_enable = 1'b0;
    ioctl_addr = 25'd5;
    ioctl_rd = 1'b1;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    checks++; if (dma_rd !== 1'b1) begin failures++; $display("FAIL abort_fetch: dma_rd %b want 1", dma_rd); end
    @(posedge clk); #1;
    ioctl_upload = 1'b0;
    @(posedge clk); #1;
    checks++; if (dma_rd !== 1'b0 || ioctl_wait !== 1'b0) begin
      failures++; $display("FAIL abort_drop: dma_rd %b wait %b want 0 0", dma_rd, ioctl_wait);
    end
    ack_enable = 1'b1;
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ioctl_din !== d0 || ioctl_wait !== 1'b0 || dma_rd !== 1'b0) begin
      failures++; $display("FAIL abort_late_ack: din %h wait %b dma_rd %b want %h 0 0", ioctl_din, ioctl_wait, dma_rd, d0);
    end
    begin_upload(16'h0123, 16'h0130);
    read_byte(0, d, w, sd, da);
    checks++; if (d !== 8'h23 || upload_size !== 17'd15) begin
      failures++; $display("FAIL abort_restart: din %h size %0d want 23 15", d, upload_size);
    end
    end_upload();
  endtask

  task automatic test_reset_in_latch();
    logic [7:0] d; int w; bit sd; logic [RAM_AW-1:0] da;
    begin_upload(16'h0300, 16'h0320);
    ack_delay = 2;
    ioctl_addr = 25'd4;
    ioctl_rd = 1'b1;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (ioctl_wait !== 1'b1 || dma_rd !== 1'b0) begin
      failures++; $display("FAIL latch_phase: wait %b dma_rd %b want 1 0", ioctl_wait, dma_rd);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (ioctl_din !== 8'h00 || ioctl_wait !== 1'b0 || dma_rd !== 1'b0 ||
                  dma_addr !== '0 || upload_size !== 17'd0) begin
      failures++; $display("FAIL latch_reset: din %h wait %b rd %b addr %h size %h want all 0",
                           ioctl_din, ioctl_wait, dma_rd, dma_addr, upload_size);
    end
    reset = 1'b0;
    ioctl_upload = 1'b0;
    @(posedge clk); #1;
    begin_upload(16'h1234, 16'h1240);
    read_byte(1, d, w, sd, da);
    checks++; if (d !== 8'h12 || upload_size !== 17'd14) begin
      failures++; $display("FAIL latch_restart: din %h size %0d want 12 14", d, upload_size);
    end
    end_upload();
  endtask

  task automatic test_wrap();
    logic [7:0] d; int w; bit sd; logic [RAM_AW-1:0] da;
    int size;
    size = model_size(16'h3FFF, 16'h4010);
    ack_delay = 2;
    begin_upload(16'h3FFF, 16'h4010);
    read_byte(3, d, w, sd, da);
`ifdef PRG_SAVE_BOUNDS_EN
    checks++; if (d !== 8'hFF || sd || w != 0) begin
      failures++; $display("FAIL wrap_bounds: din %h dma %b wait %0d want ff 0 0", d, sd, w);
    end
`else
    checks++; if (da !== '0 || !sd || d !== ram[0]) begin
      failures++; $display("FAIL wrap_trunc: addr %h dma %b din %h want 0 1 %h", da, sd, d, ram[0]);
    end
`endif
    checks++; if (d !== model_byte(16'h3FFF, size, 3)) begin
      failures++; $display("FAIL wrap_model: din %h want %h", d, model_byte(16'h3FFF, size, 3));
    end
    end_upload();
  endtask

  initial begin
    for (int i = 0; i < RAM_SZ; i++) ram[i] = 8'($urandom);
    test_reset();
    test_header();
    test_fetch();
    test_empty();
    test_random();
    test_ignore_during_wait();
    test_abort();
    test_reset_in_latch();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
